// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder for a multicycle CPU.
// Samples a level-held read/write request once, serves it from an internal
// word array after LATENCY cycles, and pulses inputReady (read) or ackOutput
// (write) for one cycle. A request still held after its response is parked in
// WAIT_LOW until it drops, so it is never served twice.
//
// Ports
//   clk          in   clock, rising edge
//   Reset        in   asynchronous active-high reset
//   readM        in   read request (level)
//   writeM       in   write request (level)
//   address      in   word address, low ADDR_BITS used
//   data_wr      in   write data
//   data_rd      out  read data, held until the next read response
//   inputReady   out  one-cycle read-valid pulse
//   ackOutput    out  one-cycle write-committed pulse
//   busy         out  high whenever the FSM is not idle
//   protocol_err out  one-cycle pulse when readM and writeM were both high at accept
module mem_responder #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] data_wr,
    output logic [WORD_SIZE-1:0] data_rd,
    output logic                 inputReady,
    output logic                 ackOutput,
    output logic                 busy,
    output logic                 protocol_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY     = 2'd1,
        S_RESP     = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic                   r_is_read;
    logic [WORD_SIZE-1:0]   r_mem [DEPTH];

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [ADDR_BITS-1:0]   w_addr_nxt;
    logic [WORD_SIZE-1:0]   w_wdata_nxt;
    logic                   w_is_read_nxt;
    logic [WORD_SIZE-1:0]   w_data_rd_nxt;
    logic                   w_ready_nxt;
    logic                   w_ack_nxt;
    logic                   w_perr_nxt;
    logic                   w_mem_we;
    logic                   w_req;

    assign w_req = readM | writeM;

    // Address bits above ADDR_BITS are deliberately ignored (address wraps).
    if (ADDR_BITS < WORD_SIZE) begin : g_addr_hi
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_is_read_nxt = r_is_read;
        w_data_rd_nxt = data_rd;
        w_ready_nxt   = 1'b0;
        w_ack_nxt     = 1'b0;
        w_perr_nxt    = 1'b0;
        w_mem_we      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt   = S_BUSY;
                    w_cnt_nxt     = CNT_W'(LATENCY - 1);
                    w_addr_nxt    = address[ADDR_BITS-1:0];
                    w_wdata_nxt   = data_wr;
                    // Read wins when both are requested.
                    w_is_read_nxt = readM;
                    w_perr_nxt    = readM & writeM;
                end
            end
            S_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = S_RESP;
                    if (r_is_read) begin
                        w_data_rd_nxt = r_mem[r_addr];
                        w_ready_nxt   = 1'b1;
                    end else begin
                        w_mem_we  = 1'b1;
                        w_ack_nxt = 1'b1;
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = w_req ? S_WAIT_LOW : S_IDLE;
            end
            S_WAIT_LOW: begin
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_read    <= 1'b0;
            data_rd      <= '0;
            inputReady   <= 1'b0;
            ackOutput    <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_is_read    <= w_is_read_nxt;
            data_rd      <= w_data_rd_nxt;
            inputReady   <= w_ready_nxt;
            ackOutput    <= w_ack_nxt;
            busy         <= (w_state_nxt != S_IDLE);
            protocol_err <= w_perr_nxt;
        end
    end

    // Word array; not cleared by reset. A reset in flight leaves r_state idle,
    // so a pending write is never committed.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 and LATENCY=1 instances).
module tb_mem_responder;

    logic        clk;
    logic        Reset;
    logic        readM, writeM;
    logic [15:0] address, data_wr, data_rd;
    logic        inputReady, ackOutput, busy, protocol_err;

    logic        readM1, writeM1;
    logic [15:0] address1, data_wr1, data_rd1;
    logic        inputReady1, ackOutput1, busy1, protocol_err1;

    int n_checks;
    int n_fail;

    mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) dut (
        .clk(clk), .Reset(Reset), .readM(readM), .writeM(writeM),
        .address(address), .data_wr(data_wr), .data_rd(data_rd),
        .inputReady(inputReady), .ackOutput(ackOutput), .busy(busy),
        .protocol_err(protocol_err)
    );

    mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .Reset(Reset), .readM(readM1), .writeM(writeM1),
        .address(address1), .data_wr(data_wr1), .data_rd(data_rd1),
        .inputReady(inputReady1), .ackOutput(ackOutput1), .busy(busy1),
        .protocol_err(protocol_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus-only: write one word on the LATENCY=2 instance, release on ack.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        writeM = 1'b1; address = a; data_wr = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ackOutput) begin
                got = 1'b1;
                break;
            end
        end
        writeM = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL write_timeout addr=%h: no ackOutput within 20 cycles", a);
        end
        @(negedge clk);
    endtask

    // Stimulus-only: read one word on the LATENCY=2 instance, release on ready.
    task automatic do_read(input logic [15:0] a, output logic [15:0] d);
        bit got;
        got = 1'b0;
        d = 'x;
        @(negedge clk);
        readM = 1'b1; address = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inputReady) begin
                d = data_rd;
                got = 1'b1;
                break;
            end
        end
        readM = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h: no inputReady within 20 cycles", a);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({data_rd, inputReady, ackOutput, busy, protocol_err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data_rd=%h ir=%b ack=%b busy=%b perr=%b, want all 0",
                     data_rd, inputReady, ackOutput, busy, protocol_err);
        end
        n_checks++;
        if ({data_rd1, inputReady1, ackOutput1, busy1, protocol_err1} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1: got data_rd=%h ir=%b ack=%b busy=%b perr=%b, want all 0",
                     data_rd1, inputReady1, ackOutput1, busy1, protocol_err1);
        end
        Reset = 1'b0;
    endtask

    // Write BEEF @0x0010: ack two edges after accept, busy for three cycles.
    task automatic test_write_latency;
        logic [4:0] exp_busy;
        logic [4:0] exp_ack;
        exp_busy = 5'b00111;
        exp_ack  = 5'b00100;
        @(negedge clk);
        writeM = 1'b1; address = 16'h0010; data_wr = 16'hBEEF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== exp_busy[k] || ackOutput !== exp_ack[k]) begin
                n_fail++;
                $display("FAIL write_timing cycle %0d: got busy=%b ack=%b, want busy=%b ack=%b",
                         k, busy, ackOutput, exp_busy[k], exp_ack[k]);
            end
            if (ackOutput) writeM = 1'b0;
        end
        writeM = 1'b0;
    endtask

    // Held read: single pulse with BEEF, parked until readM drops.
    task automatic test_held_read;
        logic [5:0] exp_ir;
        exp_ir = 6'b000100;
        @(negedge clk);
        readM = 1'b1; address = 16'h0010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (inputReady !== exp_ir[k] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL held_read cycle %0d: got ir=%b busy=%b, want ir=%b busy=1",
                         k, inputReady, busy, exp_ir[k]);
            end
            if (k == 2) begin
                n_checks++;
                if (data_rd !== 16'hBEEF) begin
                    n_fail++;
                    $display("FAIL held_read_data: got %h, want BEEF", data_rd);
                end
            end
        end
        readM = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || inputReady !== 1'b0 || data_rd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL held_read_release: got busy=%b ir=%b data_rd=%h, want 0 0 BEEF",
                     busy, inputReady, data_rd);
        end
    endtask

    // Both requests high: read served, protocol_err once, memory untouched.
    task automatic test_both_requests;
        logic [3:0] exp_perr;
        logic [3:0] exp_ir;
        logic [15:0] rd;
        int perr_cnt;
        exp_perr = 4'b0001;
        exp_ir   = 4'b0100;
        perr_cnt = 0;
        @(negedge clk);
        readM = 1'b1; writeM = 1'b1; address = 16'h0010; data_wr = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (protocol_err) perr_cnt++;
            n_checks++;
            if (protocol_err !== exp_perr[k] || inputReady !== exp_ir[k] || ackOutput !== 1'b0) begin
                n_fail++;
                $display("FAIL both_req cycle %0d: got perr=%b ir=%b ack=%b, want perr=%b ir=%b ack=0",
                         k, protocol_err, inputReady, ackOutput, exp_perr[k], exp_ir[k]);
            end
            if (inputReady) begin
                n_checks++;
                if (data_rd !== 16'hBEEF) begin
                    n_fail++;
                    $display("FAIL both_req_data: got %h, want BEEF", data_rd);
                end
                readM = 1'b0; writeM = 1'b0;
            end
        end
        n_checks++;
        if (perr_cnt != 1) begin
            n_fail++;
            $display("FAIL both_req_perr_count: got %0d pulses, want 1", perr_cnt);
        end
        do_read(16'h0010, rd);
        n_checks++;
        if (rd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL both_req_mem_unchanged: got %h, want BEEF", rd);
        end
    endtask

    // Upper address bits ignored.
    task automatic test_addr_wrap;
        logic [15:0] rd;
        do_write(16'h0105, 16'h00AA);
        do_read(16'h0005, rd);
        n_checks++;
        if (rd !== 16'h00AA) begin
            n_fail++;
            $display("FAIL addr_wrap_0005: got %h, want 00AA", rd);
        end
        do_read(16'hFF05, rd);
        n_checks++;
        if (rd !== 16'h00AA) begin
            n_fail++;
            $display("FAIL addr_wrap_FF05: got %h, want 00AA", rd);
        end
    endtask

    // Reset mid-BUSY on a write: outputs clear at once, write dropped.
    task automatic test_reset_mid_busy;
        logic [15:0] rd;
        int ack_seen;
        ack_seen = 0;
        do_write(16'h0020, 16'h1111);
        @(negedge clk);
        writeM = 1'b1; address = 16'h0020; data_wr = 16'h5555;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy_pre: got busy=%b, want 1", busy);
        end
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({data_rd, inputReady, ackOutput, busy, protocol_err} !== 20'h0) begin
            n_fail++;
            $display("FAIL rst_mid_busy_outputs: got data_rd=%h ir=%b ack=%b busy=%b perr=%b, want all 0",
                     data_rd, inputReady, ackOutput, busy, protocol_err);
        end
        writeM = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ackOutput) ack_seen++;
        end
        Reset = 1'b0;
        @(negedge clk);
        if (ackOutput) ack_seen++;
        n_checks++;
        if (ack_seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_busy_ack: got %0d ack pulses, want 0", ack_seen);
        end
        do_read(16'h0020, rd);
        n_checks++;
        if (rd !== 16'h1111) begin
            n_fail++;
            $display("FAIL rst_mid_busy_mem: got %h, want 1111", rd);
        end
    endtask

    // LATENCY=1 instance: response one edge after accept, requests 3 cycles apart.
    task automatic test_back_to_back;
        logic [5:0] exp_ir;
        logic [5:0] exp_busy;
        exp_ir   = 6'b010010;
        exp_busy = 6'b011011;
        @(negedge clk);
        writeM1 = 1'b1; address1 = 16'h0003; data_wr1 = 16'h0ABC;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ackOutput1 !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1_write_ack: got ack=%b, want 1", ackOutput1);
        end
        writeM1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        readM1 = 1'b1; address1 = 16'h0003;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            n_checks++;
            if (inputReady1 !== exp_ir[j] || busy1 !== exp_busy[j]) begin
                n_fail++;
                $display("FAIL lat1_b2b cycle %0d: got ir=%b busy=%b, want ir=%b busy=%b",
                         j, inputReady1, busy1, exp_ir[j], exp_busy[j]);
            end
            if (inputReady1) begin
                n_checks++;
                if (data_rd1 !== 16'h0ABC) begin
                    n_fail++;
                    $display("FAIL lat1_b2b_data cycle %0d: got %h, want 0ABC", j, data_rd1);
                end
                readM1 = 1'b0;
            end else begin
                readM1 = 1'b1;
            end
        end
        readM1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset = 1'b1;
        readM = 1'b0; writeM = 1'b0; address = '0; data_wr = '0;
        readM1 = 1'b0; writeM1 = 1'b0; address1 = '0; data_wr1 = '0;

        test_reset();
        test_write_latency();
        test_held_read();
        test_both_requests();
        test_addr_wrap();
        test_reset_mid_busy();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
